mode_scheduler: RTL and testbench
=================================

// Module: mode_scheduler
// PURPOSE
//  Sequences the clock's display modes (0 clock, 1 terminator, 2 marquee, 3 timer).
//  Debounces the mode key and steps through the modes with a clean break-before-make:
//  every enable drops and the display blanks before the next mode is enabled.
//  Owns the one-hot mode enables and a registered seg/LED mux driving the board outputs.
//  Sits between the mode sub-blocks and the HEX/LED pins. Runs on the board clock, not the 1 Hz pulse.
// PARAMETERS
//  NUM_MODES        4        modes in rotation, 2..4; mode index is always 2 bits
//  DEBOUNCE_CYCLES  500000   consecutive stable samples to accept a key level (10 ms @ 50 MHz)
//  BLANK_CYCLES     4        cycles in DRAIN with all enables low and display blank, >=1
//  AUTO_PERIOD      10       tick_1hz pulses between auto-advances (AUTO_CYCLE_EN only)
// PORTS
//  clk        in   1               board clock, rising edge
//  reset      in   1               asynchronous, active-low; 0 = reset
//  mode_btn   in   1               raw mode key, active-low (0 = pressed), asynchronous
//  tick_1hz   in   1               one-clk-wide 1 Hz pulse, clk domain
//  seg_in     in   28*NUM_MODES    mode m occupies [28m+27:28m]; digit d (0..3) = [28m+7d+6:28m+7d]
//  led_in     in   10*NUM_MODES    mode m occupies [10m+9:10m]
//  seg_out    out  28              registered 4-digit segments, digit d = [7d+6:7d], active-low
//  led_out    out  10              registered LEDs
//  mode_en    out  NUM_MODES       one-hot enable of the active mode; all 0 while switching
//  mode       out  2               current mode index
//  busy       out  1               1 while in DRAIN or ARM
// BEHAVIOUR
//  Reset (async, reset=0): state RUN, mode=0, mode_en=1 (mode 0 only), busy=0,
//   seg_out=28'h FFFFFFF (blank), led_out=0, debounce stable level=1, counter=0.
//  Key path: 2-FF synchroniser; counter clears whenever synced != stable level; when the
//   counter reaches DEBOUNCE_CYCLES-1 with synced still != stable, stable level takes synced.
//   A stable 1->0 change gives a 1-cycle press pulse. Release makes no pulse.
//  FSM:
//   RUN   : press -> DRAIN next cycle. mode_en=onehot(mode), busy=0.
//   DRAIN : mode_en=0, busy=1, display blank. Stays exactly BLANK_CYCLES cycles, then ARM.
//   ARM   : 1 cycle. mode <= (mode==NUM_MODES-1) ? 0 : mode+1; mode_en <= onehot(new mode); -> RUN.
//  Press at cycle T: mode_en=0 at T+1, new mode/mode_en visible at T+BLANK_CYCLES+2.
//  Presses during DRAIN/ARM are dropped, not queued.
//  Output mux: in RUN, seg_out/led_out <= slice[mode] each cycle (1-cycle latency).
//   In DRAIN/ARM, seg_out <= all 1s and led_out <= 0.
//  Wrap: mode NUM_MODES-1 -> 0. mode_en is never multi-hot. In RUN it is never all-zero.
//  Reset asserted mid-DRAIN/ARM: immediately returns to the reset state, with no pending switch.
//  Key held: exactly one switch per debounced press. Bounces shorter than DEBOUNCE_CYCLES are ignored.
// CONFIGURATION
//  AUTO_CYCLE_EN defined: an auto counter (0..AUTO_PERIOD-1) increments on tick_1hz in RUN only.
//   On reaching AUTO_PERIOD it raises an internal advance request (same path as a press) and clears.
//   Counter clears on entering DRAIN from any cause and on reset.
//   Press and auto request in the same cycle give a single switch.
//  AUTO_CYCLE_EN undefined: no auto counter; tick_1hz is ignored; only key presses switch mode.
// TESTING
//  1 Reset with seg_in mode0=28'h0000001 -> after release mode=0, mode_en=4'b0001, busy=0;
//    seg_out=28'h0000001 one cycle later.
//  2 Clean press (DEBOUNCE_CYCLES=8, BLANK_CYCLES=4) -> busy=1 and mode_en=0 for 5 cycles,
//    seg_out=28'hFFFFFFF; then mode=1, mode_en=4'b0010, and seg_out=mode1 slice after 1 cycle.
//  3 Four presses from mode 0 -> modes 1,2,3,0; mode_en 0010,0100,1000,0001.
//  4 Key bouncing 0/1 every 3 cycles for 40 cycles, then held 0 (DEBOUNCE_CYCLES=8) -> exactly one switch.
//  5 Second press while busy=1 -> ignored; mode advances by 1 only.
//    Reset pulsed during DRAIN -> mode=0, mode_en=0001 at once.
//  6 AUTO_CYCLE_EN, AUTO_PERIOD=3 -> switch after every 3rd tick_1hz.
//    Press coincident with the 3rd tick -> single advance.
//    Without the macro, 10 ticks -> mode stays unchanged.

Source files
------------

// File: rtl/mode_scheduler.sv
// mode_scheduler: debounced mode-key sequencer for the display clock.
// Rotates through the display modes with break-before-make switching:
// all enables drop and the display blanks for BLANK_CYCLES, then the next
// mode is armed. Registered seg/LED mux feeds the board pins.
// Optional feature macro: AUTO_CYCLE_EN (auto-advance every AUTO_PERIOD
// tick_1hz pulses while running). Default build: key presses only.
module mode_scheduler #(
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_CYCLES    = 4,
  parameter int AUTO_PERIOD     = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode_btn,
  input  logic                    tick_1hz,
  input  logic [28*NUM_MODES-1:0] seg_in,
  input  logic [10*NUM_MODES-1:0] led_in,
  output logic [27:0]             seg_out,
  output logic [9:0]              led_out,
  output logic [NUM_MODES-1:0]    mode_en,
  output logic [1:0]              mode,
  output logic                    busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]      MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ARM   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_stable;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_press;
  logic [BL_W-1:0]        r_blank_cnt;
  logic [1:0]             r_mode;
  logic [1:0]             w_mode_nxt;
  logic [NUM_MODES-1:0]   r_mode_en;
  logic [27:0]            r_seg_out;
  logic [9:0]             r_led_out;
  logic [27:0]            w_seg_sel;
  logic [9:0]             w_led_sel;
  logic                   w_busy;
  logic                   w_auto_req;
  logic                   w_advance;

  function automatic logic [NUM_MODES-1:0] onehot(input logic [1:0] idx);
    logic [NUM_MODES-1:0] v;
    v = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (idx == 2'(m)) v[m] = 1'b1;
    end
    return v;
  endfunction

  // Two-flop synchroniser for the asynchronous, active-low mode key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= mode_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // a newly accepted low level emits a single-cycle press pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_stable) begin
        if (r_db_cnt == DB_LAST) begin
          r_stable <= r_sync2;
          r_db_cnt <= '0;
          r_press  <= ~r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam int AU_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AU_W-1:0] AU_LAST = AU_W'(AUTO_PERIOD - 1);
  logic [AU_W-1:0] r_auto_cnt;

  assign w_auto_req = (r_state == ST_RUN) && tick_1hz && (r_auto_cnt == AU_LAST);

  // Auto-advance counter: counts ticks only while running, restarts on every switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_auto_cnt <= '0;
    end else if ((r_state != ST_RUN) || w_advance) begin
      r_auto_cnt <= '0;
    end else if (tick_1hz) begin
      r_auto_cnt <= r_auto_cnt + AU_W'(1);
    end
  end
`else
  localparam int unused_auto_period = AUTO_PERIOD;
  logic w_unused_tick;
  assign w_unused_tick = tick_1hz;
  assign w_auto_req    = 1'b0;
`endif

  // A press and an auto request in the same cycle collapse into one advance.
  assign w_advance  = r_press | w_auto_req;
  assign w_mode_nxt = (r_mode == MODE_LAST) ? 2'd0 : r_mode + 2'd1;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; requests outside RUN fall through and are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_advance) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (r_blank_cnt == BL_LAST) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Blanking interval length counter, held at zero outside DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_blank_cnt <= '0;
    else if (r_state == ST_DRAIN) r_blank_cnt <= r_blank_cnt + BL_W'(1);
    else                        r_blank_cnt <= '0;
  end

  // Mode index and enables: break on leaving RUN, make on ARM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= 2'd0;
      r_mode_en <= onehot(2'd0);
    end else begin
      if ((r_state == ST_RUN) && w_advance) begin
        r_mode_en <= '0;
      end else if (r_state == ST_ARM) begin
        r_mode    <= w_mode_nxt;
        r_mode_en <= onehot(w_mode_nxt);
      end
    end
  end

  // Select the active mode's segment and LED slices.
  always_comb begin
    w_seg_sel = 28'hFFFFFFF;
    w_led_sel = 10'd0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (r_mode == 2'(m)) begin
        w_seg_sel = seg_in[28*m +: 28];
        w_led_sel = led_in[10*m +: 10];
      end
    end
  end

  // Registered output mux; blank display whenever a switch is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_out <= 28'hFFFFFFF;
      r_led_out <= 10'd0;
    end else if (r_state == ST_RUN) begin
      r_seg_out <= w_seg_sel;
      r_led_out <= w_led_sel;
    end else begin
      r_seg_out <= 28'hFFFFFFF;
      r_led_out <= 10'd0;
    end
  end

  assign seg_out = r_seg_out;
  assign led_out = r_led_out;
  assign mode_en = r_mode_en;
  assign mode    = r_mode;
  assign busy    = w_busy;

endmodule

// File: tb/tb_mode_scheduler.sv
// Directed bench for mode_scheduler: reset state, clean press timing,
// rotation table with wrap, bounce rejection, dropped press while busy,
// reset mid-switch and tick_1hz behaviour (auto-advance when built with it).
module tb_mode_scheduler;

  localparam int NM = 4;
  localparam int DB = 8;
  localparam int BL = 4;
  localparam int AP = 3;

  localparam logic [27:0] SEG0 = 28'h0000001;
  localparam logic [27:0] SEG1 = 28'h1234567;
  localparam logic [27:0] SEG2 = 28'hABCDEF0;
  localparam logic [27:0] SEG3 = 28'h5A5A5A5;
  localparam logic [9:0]  LED0 = 10'h001;
  localparam logic [9:0]  LED1 = 10'h155;
  localparam logic [9:0]  LED2 = 10'h2AA;
  localparam logic [9:0]  LED3 = 10'h3FF;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, btn, btn2, tick;
  logic [28*NM-1:0] seg_in;
  logic [10*NM-1:0] led_in;
  logic [27:0]      seg_out, seg_out2;
  logic [9:0]       led_out, led_out2;
  logic [NM-1:0]    mode_en, mode_en2;
  logic [1:0]       mode, mode2;
  logic             busy, busy2;

  mode_scheduler #(.NUM_MODES(NM), .DEBOUNCE_CYCLES(DB), .BLANK_CYCLES(BL), .AUTO_PERIOD(AP)) u_dut (
    .clk(clk), .reset(reset), .mode_btn(btn), .tick_1hz(tick),
    .seg_in(seg_in), .led_in(led_in), .seg_out(seg_out), .led_out(led_out),
    .mode_en(mode_en), .mode(mode), .busy(busy)
  );

  // Short debounce, long blanking: lets a second press land inside the busy window.
  mode_scheduler #(.NUM_MODES(NM), .DEBOUNCE_CYCLES(2), .BLANK_CYCLES(16), .AUTO_PERIOD(AP)) u_dut2 (
    .clk(clk), .reset(reset), .mode_btn(btn2), .tick_1hz(1'b0),
    .seg_in(seg_in), .led_in(led_in), .seg_out(seg_out2), .led_out(led_out2),
    .mode_en(mode_en2), .mode(mode2), .busy(busy2)
  );

  typedef struct {
    logic [1:0]  exp_mode;
    logic [3:0]  exp_en;
    logic [27:0] exp_seg;
    logic [9:0]  exp_led;
  } rot_t;

  rot_t rot [4];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full debounced press on the main DUT, then release and let everything settle.
  task automatic press_settle();
    int w;
    w   = 0;
    btn = 1'b0;
    while (!busy && w < 60) begin
      cyc();
      w++;
    end
    check("press_busy_seen", 32'(busy), 32'd1);
    btn = 1'b1;
    w   = 0;
    while (busy && w < 60) begin
      cyc();
      w++;
    end
    check("press_busy_clear", 32'(busy), 32'd0);
    repeat (14) cyc();
  endtask

  initial begin
    int         lat, nb, rises, w;
    logic       saw_busy, prev;
    logic [1:0] m0;

    reset  = 1'b0;
    btn    = 1'b1;
    btn2   = 1'b1;
    tick   = 1'b0;
    seg_in = {SEG3, SEG2, SEG1, SEG0};
    led_in = {LED3, LED2, LED1, LED0};
    rot[0] = '{2'd2, 4'b0100, SEG2, LED2};
    rot[1] = '{2'd3, 4'b1000, SEG3, LED3};
    rot[2] = '{2'd0, 4'b0001, SEG0, LED0};
    rot[3] = '{2'd1, 4'b0010, SEG1, LED1};

    @(negedge clk);
    repeat (2) cyc();

    // Reset state
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_mode_en", 32'(mode_en), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seg", 32'(seg_out), 32'(BLANK));
    check("rst_led", 32'(led_out), 32'd0);
    reset = 1'b1;
    cyc();
    check("run_seg_mode0", 32'(seg_out), 32'(SEG0));
    check("run_led_mode0", 32'(led_out), 32'(LED0));
    check("run_mode_en0", 32'(mode_en), 32'd1);

    // Clean press: 5 busy cycles with enables low, display blank, then mode 1
    btn = 1'b0;
    lat = 0;
    while (!busy && lat < 60) begin
      cyc();
      lat++;
    end
    check("press_busy", 32'(busy), 32'd1);
    check("press_latency_in_range", 32'((lat >= DB + 1) && (lat <= DB + 4)), 32'd1);
    nb = 0;
    while (busy && nb < 20) begin
      check("drain_mode_en_zero", 32'(mode_en), 32'd0);
      if (nb == 1) begin
        check("drain_seg_blank", 32'(seg_out), 32'(BLANK));
        check("drain_led_zero", 32'(led_out), 32'd0);
      end
      cyc();
      nb++;
    end
    check("busy_length", 32'(nb), 32'(BL + 1));
    check("switch_mode", 32'(mode), 32'd1);
    check("switch_mode_en", 32'(mode_en), 32'b0010);
    cyc();
    check("switch_seg_mode1", 32'(seg_out), 32'(SEG1));
    check("switch_led_mode1", 32'(led_out), 32'(LED1));
    repeat (20) cyc();
    check("held_key_one_switch", 32'(mode), 32'd1);
    btn = 1'b1;
    repeat (16) cyc();
    check("release_no_switch", 32'(mode), 32'd1);

    // Rotation table including wrap to mode 0
    for (int i = 0; i < 4; i++) begin
      press_settle();
      check("rot_mode", 32'(mode), 32'(rot[i].exp_mode));
      check("rot_mode_en", 32'(mode_en), 32'(rot[i].exp_en));
      check("rot_seg", 32'(seg_out), 32'(rot[i].exp_seg));
      check("rot_led", 32'(led_out), 32'(rot[i].exp_led));
    end

    // Bouncing key: ignored while bouncing, then one switch once held
    saw_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) btn = ~btn;
      cyc();
      if (busy) saw_busy = 1'b1;
    end
    check("bounce_ignored", 32'(saw_busy), 32'd0);
    check("bounce_mode_kept", 32'(mode), 32'd1);
    btn   = 1'b0;
    rises = 0;
    prev  = busy;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (busy && !prev) rises++;
      prev = busy;
    end
    btn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("bounce_one_switch", 32'(rises), 32'd1);
    check("bounce_mode", 32'(mode), 32'd2);

    // Second press while busy is dropped (second instance)
    btn2 = 1'b0;
    w    = 0;
    while (!busy2 && w < 40) begin
      cyc();
      w++;
    end
    check("dut2_busy", 32'(busy2), 32'd1);
    btn2 = 1'b1;
    repeat (5) cyc();
    btn2 = 1'b0;
    repeat (5) cyc();
    check("dut2_still_busy", 32'(busy2), 32'd1);
    btn2 = 1'b1;
    w = 0;
    while (busy2 && w < 60) begin
      cyc();
      w++;
    end
    repeat (10) cyc();
    check("dut2_single_advance", 32'(mode2), 32'd1);
    check("dut2_mode_en", 32'(mode_en2), 32'b0010);
    check("dut2_idle", 32'(busy2), 32'd0);

    // Reset pulsed during DRAIN
    btn = 1'b0;
    w   = 0;
    while (!busy && w < 60) begin
      cyc();
      w++;
    end
    btn = 1'b1;
    cyc();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midreset_mode", 32'(mode), 32'd0);
    check("midreset_mode_en", 32'(mode_en), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_seg", 32'(seg_out), 32'(BLANK));
    @(negedge clk);
    reset = 1'b1;
    repeat (20) cyc();
    check("no_pending_mode", 32'(mode), 32'd0);
    check("no_pending_mode_en", 32'(mode_en), 32'd1);
    check("after_reset_seg", 32'(seg_out), 32'(SEG0));

`ifdef AUTO_CYCLE_EN
    // Auto advance on every third tick
    for (int k = 1; k <= AP; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      check("auto_busy_after_tick", 32'(busy), 32'(k == AP));
      repeat (3) cyc();
    end
    repeat (10) cyc();
    check("auto_mode", 32'(mode), 32'd1);
    // Press coincident with the third tick gives one advance
    for (int k = 1; k < AP; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (3) cyc();
    end
    btn = 1'b0;
    repeat (10) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("coincident_busy", 32'(busy), 32'd1);
    repeat (6) cyc();
    btn = 1'b1;
    repeat (24) cyc();
    check("coincident_single_advance", 32'(mode), 32'd2);
`else
    // Without auto-cycle, ticks never switch
    m0       = mode;
    saw_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      if (busy) saw_busy = 1'b1;
    end
    check("ticks_no_busy", 32'(saw_busy), 32'd0);
    check("ticks_mode_kept", 32'(mode), 32'(m0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
